falafel_mem_atomic_adapter: RTL
===============================

// Module: falafel_mem_atomic_adapter
// PURPOSE
//  Sits directly downstream of falafel_core's memory request/response port.
//  Accepts core reads, writes and compare-and-swaps and drives a plain single-port read/write bus.
//  Executes each CAS as a locked read-compare-conditional-write sequence.
//  Returns one response per request to the core.
// PARAMETERS
//  DATA_W   falafel_pkg::DATA_W  width of address, data and CAS expected value
//  STAT_W   16                   width of the CAS-failure counter (FALAFEL_MEM_ADAPTER_STATS_EN only)
// PORTS
//  clk_i               in   1       clock
//  rst_i               in   1       reset: asynchronous, active-high
//  mem_req_val_i       in   1       core request valid
//  mem_req_rdy_o       out  1       adapter ready; request accepted when val && rdy
//  mem_req_is_write_i  in   1       1 = write, 0 = read
//  mem_req_is_cas_i    in   1       1 = CAS; overrides is_write
//  mem_req_addr_i      in   DATA_W  address
//  mem_req_data_i      in   DATA_W  write data / CAS new value
//  mem_req_cas_exp_i   in   DATA_W  CAS expected value
//  mem_rsp_val_o       out  1       response valid to core
//  mem_rsp_rdy_i       in   1       core ready for response
//  mem_rsp_data_o      out  DATA_W  response data
//  bus_req_val_o       out  1       bus request valid
//  bus_req_rdy_i       in   1       bus accepts request
//  bus_req_we_o        out  1       1 = write
//  bus_req_addr_o      out  DATA_W  bus address
//  bus_req_wdata_o     out  DATA_W  bus write data
//  bus_lock_o          out  1       bus held for an atomic sequence
//  bus_rsp_val_i       in   1       one-cycle pulse per accepted bus request (reads and writes)
//  bus_rsp_data_i      in   DATA_W  read data; ignored for writes
//  cas_fail_cnt_o      out  STAT_W  failed-CAS count (port exists only under the macro)
// BEHAVIOUR
//  - Reset: all outputs 0, counter 0, state IDLE.
//    Asserting rst_i mid-sequence drops the transaction, releases bus_lock_o and emits no response.
//  - States: IDLE, BUS_REQ, BUS_WAIT, CAS_CMP, CAS_WR_REQ, CAS_WR_WAIT, RSP.
//  - mem_req_rdy_o = (state == IDLE), combinational.
//    On accept, register op/addr/data/exp and go to BUS_REQ on the next edge.
//  - BUS_REQ: bus_req_val_o = 1 and stays stable until bus_req_rdy_i.
//    bus_req_we_o = (is_write && !is_cas). Then go to BUS_WAIT.
//  - BUS_WAIT: on bus_rsp_val_i:
//    - read: capture bus_rsp_data_i; go to RSP.
//    - write: load wdata as response data; go to RSP.
//    - CAS: capture old value; go to CAS_CMP.
//  - CAS_CMP (1 cycle):
//    - old == exp: go to CAS_WR_REQ.
//    - otherwise: cas_fail count +1; go to RSP.
//  - CAS_WR_REQ / CAS_WR_WAIT: bus write of the new value to the same address.
//    On bus_rsp_val_i go to RSP.
//  - CAS response data is always the old value; the core infers success by comparing it to exp.
//  - bus_lock_o is 1 from CAS entry to BUS_REQ until RSP entry, inclusive of the CAS_CMP cycle.
//  - RSP: mem_rsp_val_o = 1 and mem_rsp_data_o stays stable until mem_rsp_rdy_i; then go to IDLE.
//    Back-to-back core requests are therefore ≥1 idle cycle apart.
//  - Minimum latency with zero-wait bus (accept to rsp_val):
//    - read/write: 3 cycles.
//    - CAS success: 6 cycles.
//    - CAS fail: 4 cycles.
//  - bus_rsp_val_i outside BUS_WAIT / CAS_WR_WAIT is ignored.
//    bus_rsp_val_i in the same cycle as bus_req_rdy_i is illegal (bus contract).
//  - mem_rsp_rdy_i held high: response still lasts exactly one cycle.
//    No new request is accepted in that cycle.
// CONFIGURATION
//  FALAFEL_MEM_ADAPTER_STATS_EN defined:
//    - cas_fail_cnt_o exists and increments once per failed CAS.
//    - The counter saturates at all-ones and is cleared by rst_i.
//  Undefined: the port and counter are absent; behaviour is otherwise identical.
// STRUCTURE
//  falafel_pkg gains:
//    - typedef enum logic [2:0] mem_adapter_state_e (the states above).
//    - typedef struct packed mem_op_t {is_write, is_cas, addr, data, cas_exp}.
//  Sub-module falafel_sat_counter #(W), used only under the macro. Everything else is inline.
// TESTING
//  1 read addr 0x40, bus returns 0xDEAD -> mem_rsp_data_o = 0xDEAD, bus_req_we_o = 0, 3-cycle latency.
//  2 write addr 0x48 data 0x1234 -> one bus write with we = 1, wdata 0x1234; response data 0x1234.
//  3 CAS addr 0x50, exp 0x0, new 0x7, bus read returns 0x0
//      -> second bus write of 0x7 to 0x50; response 0x0; lock high throughout.
//  4 CAS exp 0x0, bus read returns 0x5
//      -> no bus write; response 0x5; cas_fail_cnt_o = 1 under the macro.
//  5 bus_req_rdy_i low for 4 cycles and mem_rsp_rdy_i low for 3 cycles
//      -> bus request and response held stable; no second request accepted.
//  6 rst_i asserted in CAS_WR_WAIT
//      -> all outputs 0 immediately; a later read completes normally.

Source files
------------

// File: rtl/falafel_mem_atomic_adapter_pkg.sv
// Shared types for the falafel memory atomic adapter: data width, FSM states, captured request.
package falafel_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_BUS_REQ     = 3'd1,
    ST_BUS_WAIT    = 3'd2,
    ST_CAS_CMP     = 3'd3,
    ST_CAS_WR_REQ  = 3'd4,
    ST_CAS_WR_WAIT = 3'd5,
    ST_RSP         = 3'd6
  } mem_adapter_state_e;

  typedef struct packed {
    logic              is_write;
    logic              is_cas;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] cas_exp;
  } mem_op_t;

endpackage

// File: rtl/falafel_mem_atomic_adapter_if.sv
// Core memory port plus single-port bus bundle for falafel_mem_atomic_adapter.
// Names keep the adapter's view: _i flows into the adapter, _o flows out of it.
interface falafel_mem_atomic_adapter_if
  import falafel_pkg::*;
#(
  parameter int DATA_W = falafel_pkg::DATA_W
) ();

  logic              mem_req_val_i;
  logic              mem_req_rdy_o;
  logic              mem_req_is_write_i;
  logic              mem_req_is_cas_i;
  logic [DATA_W-1:0] mem_req_addr_i;
  logic [DATA_W-1:0] mem_req_data_i;
  logic [DATA_W-1:0] mem_req_cas_exp_i;
  logic              mem_rsp_val_o;
  logic              mem_rsp_rdy_i;
  logic [DATA_W-1:0] mem_rsp_data_o;
  logic              bus_req_val_o;
  logic              bus_req_rdy_i;
  logic              bus_req_we_o;
  logic [DATA_W-1:0] bus_req_addr_o;
  logic [DATA_W-1:0] bus_req_wdata_o;
  logic              bus_lock_o;
  logic              bus_rsp_val_i;
  logic [DATA_W-1:0] bus_rsp_data_i;

  modport slave (
    input  mem_req_val_i, mem_req_is_write_i, mem_req_is_cas_i,
    input  mem_req_addr_i, mem_req_data_i, mem_req_cas_exp_i,
    input  mem_rsp_rdy_i, bus_req_rdy_i, bus_rsp_val_i, bus_rsp_data_i,
    output mem_req_rdy_o, mem_rsp_val_o, mem_rsp_data_o,
    output bus_req_val_o, bus_req_we_o, bus_req_addr_o, bus_req_wdata_o, bus_lock_o
  );

  modport master (
    output mem_req_val_i, mem_req_is_write_i, mem_req_is_cas_i,
    output mem_req_addr_i, mem_req_data_i, mem_req_cas_exp_i,
    output mem_rsp_rdy_i, bus_req_rdy_i, bus_rsp_val_i, bus_rsp_data_i,
    input  mem_req_rdy_o, mem_rsp_val_o, mem_rsp_data_o,
    input  bus_req_val_o, bus_req_we_o, bus_req_addr_o, bus_req_wdata_o, bus_lock_o
  );

endinterface

// File: rtl/falafel_mem_atomic_adapter_sat_counter.sv
// Saturating up-counter for adapter statistics; built only with FALAFEL_MEM_ADAPTER_STATS_EN.
`ifdef FALAFEL_MEM_ADAPTER_STATS_EN
module falafel_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Increment unless already at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/falafel_mem_atomic_adapter.sv
// Adapter from falafel_core's memory port to a single-port bus; CAS runs as a locked read-compare-write.
// FALAFEL_MEM_ADAPTER_STATS_EN adds a saturating failed-CAS counter on cas_fail_cnt_o.
module falafel_mem_atomic_adapter
  import falafel_pkg::*;
#(
  parameter int DATA_W = falafel_pkg::DATA_W
`ifdef FALAFEL_MEM_ADAPTER_STATS_EN
  ,
  parameter int STAT_W = 16
`endif
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  falafel_mem_atomic_adapter_if.slave bus_if
`ifdef FALAFEL_MEM_ADAPTER_STATS_EN
  ,
  output logic [STAT_W-1:0]           cas_fail_cnt_o
`endif
);

  mem_adapter_state_e state_q, state_d;
  mem_op_t            op_q, op_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

  logic mem_req_rdy_s;
  logic bus_req_val_s;
  logic bus_req_we_s;
  logic bus_lock_s;
  logic mem_rsp_val_s;

  assign mem_req_rdy_s = (state_q == ST_IDLE) && !rst_i;

  // Next-state and capture logic.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_req_rdy_s && bus_if.mem_req_val_i) begin
          op_d = '{is_write: bus_if.mem_req_is_write_i,
                   is_cas:   bus_if.mem_req_is_cas_i,
                   addr:     bus_if.mem_req_addr_i,
                   data:     bus_if.mem_req_data_i,
                   cas_exp:  bus_if.mem_req_cas_exp_i};
          state_d = ST_BUS_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUS_REQ: begin
        if (bus_if.bus_req_rdy_i) begin
          state_d = ST_BUS_WAIT;
        end else begin
          state_d = ST_BUS_REQ;
        end
      end
      ST_BUS_WAIT: begin
        if (!bus_if.bus_rsp_val_i) begin
          state_d = ST_BUS_WAIT;
        end else if (op_q.is_cas) begin
          rsp_data_d = bus_if.bus_rsp_data_i;
          state_d    = ST_CAS_CMP;
        end else if (op_q.is_write) begin
          rsp_data_d = op_q.data;
          state_d    = ST_RSP;
        end else begin
          rsp_data_d = bus_if.bus_rsp_data_i;
          state_d    = ST_RSP;
        end
      end
      ST_CAS_CMP: begin
        if (rsp_data_q == op_q.cas_exp) begin
          state_d = ST_CAS_WR_REQ;
        end else begin
          state_d = ST_RSP;
        end
      end
      ST_CAS_WR_REQ: begin
        if (bus_if.bus_req_rdy_i) begin
          state_d = ST_CAS_WR_WAIT;
        end else begin
          state_d = ST_CAS_WR_REQ;
        end
      end
      ST_CAS_WR_WAIT: begin
        if (bus_if.bus_rsp_val_i) begin
          state_d = ST_RSP;
        end else begin
          state_d = ST_CAS_WR_WAIT;
        end
      end
      ST_RSP: begin
        if (bus_if.mem_rsp_rdy_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RSP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      rsp_data_q <= {DATA_W{1'b0}};
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Output decode; the lock spans the whole CAS from first bus request up to the response.
  always_comb begin
    bus_req_val_s = 1'b0;
    bus_req_we_s  = 1'b0;
    bus_lock_s    = 1'b0;
    mem_rsp_val_s = 1'b0;
    case (state_q)
      ST_BUS_REQ: begin
        bus_req_val_s = 1'b1;
        bus_req_we_s  = op_q.is_write && !op_q.is_cas;
        bus_lock_s    = op_q.is_cas;
      end
      ST_BUS_WAIT, ST_CAS_CMP: begin
        bus_lock_s = op_q.is_cas;
      end
      ST_CAS_WR_REQ: begin
        bus_req_val_s = 1'b1;
        bus_req_we_s  = 1'b1;
        bus_lock_s    = 1'b1;
      end
      ST_CAS_WR_WAIT: begin
        bus_lock_s = 1'b1;
      end
      ST_RSP: begin
        mem_rsp_val_s = 1'b1;
      end
      default: begin
        bus_req_val_s = 1'b0;
      end
    endcase
  end

  assign bus_if.mem_req_rdy_o   = mem_req_rdy_s;
  assign bus_if.mem_rsp_val_o   = mem_rsp_val_s;
  assign bus_if.mem_rsp_data_o  = rsp_data_q;
  assign bus_if.bus_req_val_o   = bus_req_val_s;
  assign bus_if.bus_req_we_o    = bus_req_we_s;
  assign bus_if.bus_req_addr_o  = op_q.addr;
  assign bus_if.bus_req_wdata_o = op_q.data;
  assign bus_if.bus_lock_o      = bus_lock_s;

`ifdef FALAFEL_MEM_ADAPTER_STATS_EN
  logic cas_fail_s;

  assign cas_fail_s = (state_q == ST_CAS_CMP) && (rsp_data_q != op_q.cas_exp);

  falafel_sat_counter #(.W(STAT_W)) u_cas_fail_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (cas_fail_s),
    .cnt_o (cas_fail_cnt_o)
  );
`endif

endmodule
